// File: rtl/ft_pkt_pkg.sv
// rtl/ft_pkt_pkg.sv - packet framing constants, FSM states and header layout for the FT245 TX arbiter
package ft_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_LENGTH,
    ST_PAYLOAD,
    ST_CHECKSUM
  } state_e;

  localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;
  localparam int         MAX_PAYLOAD   = 256;
  // Length byte carries len-1, so a 256-byte payload still fits an 8-bit counter.
  localparam int         CNT_W         = $clog2(MAX_PAYLOAD);

  typedef struct packed {
    logic [3:0] magic;
    logic [3:0] src_id;
  } hdr_t;

endpackage

// File: rtl/ft_tx_arbiter_if.sv
// rtl/ft_tx_arbiter_if.sv - source request/data bus and TX FIFO write bus of the arbiter
interface ft_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   src_req;
  logic [8*NREQ-1:0] src_len;
  logic [8*NREQ-1:0] src_data;
  logic [NREQ-1:0]   src_rd;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_wdata;
  logic              tx_winc;
  logic              tx_wfull;
  logic              busy;

  modport master (
    input  src_req, src_len, src_data, tx_wfull,
    output src_rd, grant, tx_wdata, tx_winc, busy
  );

  modport slave (
    output src_req, src_len, src_data, tx_wfull,
    input  src_rd, grant, tx_wdata, tx_winc, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching from last_grant+1 with wrap
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      last_grant,
  output logic [NREQ-1:0] pick
);

  int   idx;
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && req[j]) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// rtl/ft_tx_arbiter.sv - packet-granular round-robin writer of the FT245 TX FIFO
module ft_tx_arbiter
  import ft_pkt_pkg::*;
#(
  parameter int         NREQ      = 3,
  parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ft_tx_arbiter_if.master bus
);

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [3:0]         gidx_q, gidx_d;
  logic [3:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         chk_q, chk_d;

  logic [NREQ-1:0]    pick;
  logic [3:0]         pick_idx;
  logic [7:0]         pick_len;
  logic [7:0]         sel_data;
  logic               winc;
  hdr_t               hdr;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.src_req),
    .last_grant (last_q),
    .pick       (pick)
  );

  always_comb begin
    pick_idx = '0;
    pick_len = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = 4'(i);
        pick_len = bus.src_len[8*i +: 8];
      end
      if (grant_q[i]) begin
        sel_data = bus.src_data[8*i +: 8];
      end
    end
  end

  // Every non-IDLE state emits a byte; full simply freezes the FSM in place.
  assign winc         = (state_q != ST_IDLE) && !bus.tx_wfull;
  assign bus.tx_winc  = winc;
  assign bus.grant    = grant_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.src_rd   = (state_q == ST_PAYLOAD && winc) ? grant_q : '0;

  always_comb begin
    hdr.magic    = HDR_MAGIC;
    hdr.src_id   = gidx_q;
    bus.tx_wdata = 8'h00;
    case (state_q)
      ST_HEADER:   bus.tx_wdata = hdr;
      ST_LENGTH:   bus.tx_wdata = cnt_q;
      ST_PAYLOAD:  bus.tx_wdata = sel_data;
      ST_CHECKSUM: bus.tx_wdata = chk_q;
      default:     bus.tx_wdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.src_req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          cnt_d   = pick_len;
          chk_d   = 8'h00;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER:  if (winc) state_d = ST_LENGTH;
      ST_LENGTH:  if (winc) state_d = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (winc) begin
          chk_d = chk_q ^ sel_data;
          if (cnt_q == '0) state_d = ST_CHECKSUM;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_CHECKSUM: begin
        if (winc) begin
          last_d  = gidx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= 4'(NREQ - 1);
      cnt_q   <= '0;
      chk_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      chk_q   <= chk_d;
    end
  end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// tb/tb_ft_tx_arbiter.sv - scoreboard bench for ft_tx_arbiter with directed packet vectors
module tb_ft_tx_arbiter;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  ft_tx_arbiter #(.NREQ(NREQ), .HDR_MAGIC(4'hA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int src;
    int len;
    int first;
    int step;
    bit flush;
  } cmd_t;

  int           n_total = 0;
  int           n_pass  = 0;
  byte unsigned exp_q[$];
  byte unsigned dq[NREQ][$];
  int           lq[NREQ][$];
  int           rem[NREQ];
  cmd_t         cmd_q[$];
  logic [NREQ-1:0] pend = '0;
  int           rd_cnt[NREQ];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic load(input int s, input int len, input int first, input int step);
    cmd_t c;
    c = '{src: s, len: len, first: first, step: step, flush: 1'b0};
    cmd_q.push_back(c);
  endtask

  task automatic flush_src(input int s);
    cmd_t c;
    c = '{src: s, len: 0, first: 0, step: 0, flush: 1'b1};
    cmd_q.push_back(c);
  endtask

  task automatic expect_frame(input int s, input int len, input int first, input int step);
    byte unsigned b;
    byte unsigned c;
    c = 8'h00;
    exp_q.push_back(8'hA0 | 8'(s));
    exp_q.push_back(8'(len));
    for (int k = 0; k <= len; k++) begin
      b = 8'(first + k * step);
      exp_q.push_back(b);
      c = c ^ b;
    end
    exp_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    @(negedge clk);
    while ((bus.busy || (exp_q.size() != 0) || (|bus.src_req)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(n < 3000), 1);
  endtask

  // Source model: FWFT queues per source, popped on src_rd, req held while a packet is pending.
  initial begin : src_model
    cmd_t c;
    int   l;
    bus.src_req  = '0;
    bus.src_len  = '0;
    bus.src_data = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && dq[i].size() > 0) begin
          void'(dq[i].pop_front());
          rem[i]--;
          if (rem[i] == 0) begin
            void'(lq[i].pop_front());
            if (lq[i].size() > 0) rem[i] = lq[i][0] + 1;
          end
        end
      end
      while (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        if (c.flush) begin
          dq[c.src].delete();
          lq[c.src].delete();
          rem[c.src] = 0;
        end else begin
          for (int k = 0; k <= c.len; k++) dq[c.src].push_back(8'(c.first + k * c.step));
          if (lq[c.src].size() == 0) rem[c.src] = c.len + 1;
          lq[c.src].push_back(c.len);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        bus.src_req[i] = (lq[i].size() != 0);
        l = (lq[i].size() != 0) ? lq[i][0] : 0;
        bus.src_len[8*i +: 8]  = l[7:0];
        bus.src_data[8*i +: 8] = (dq[i].size() != 0) ? dq[i][0] : 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    pend = bus.src_rd;
    for (int i = 0; i < NREQ; i++) rd_cnt[i] += int'(bus.src_rd[i]);
    if (bus.tx_winc) begin
      if (bus.tx_wfull) check("winc_while_full", 1, 0);
      if (exp_q.size() == 0) check("unexpected_byte", int'(bus.tx_wdata), -1);
      else check("stream", int'(bus.tx_wdata), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.tx_wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) rd_cnt[i] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_winc", int'(bus.tx_winc), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_src_rd", int'(bus.src_rd), 0);
    check("rst_wdata", int'(bus.tx_wdata), 0);

    // Single source, two payload bytes, cycle-exact.
    tick();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h11);
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    load(0, 1, 8'h11, 8'h11);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("single_winc_c%0d", k), int'(bus.tx_winc), int'(k >= 1 && k <= 5));
      check($sformatf("single_rd0_c%0d", k), int'(bus.src_rd[0]), int'(k == 3 || k == 4));
      check($sformatf("single_busy_c%0d", k), int'(bus.busy), int'(k >= 1 && k <= 5));
      if (k == 1) check("single_grant", int'(bus.grant), 1);
    end
    wait_idle("single_done");

    // Round-robin between src0 and src1 from reset.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    expect_frame(0, 0, 8'h01, 0);
    expect_frame(1, 1, 8'h21, 1);
    expect_frame(0, 0, 8'h02, 0);
    load(0, 0, 8'h01, 0);
    load(0, 0, 8'h02, 0);
    load(1, 1, 8'h21, 1);
    wait_idle("rr2_done");

    // Round-robin with all three sources.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    expect_frame(0, 0, 8'h03, 0);
    expect_frame(1, 0, 8'h31, 0);
    expect_frame(2, 2, 8'h41, 2);
    expect_frame(0, 1, 8'h04, 1);
    load(0, 0, 8'h03, 0);
    load(0, 1, 8'h04, 1);
    load(1, 0, 8'h31, 0);
    load(2, 2, 8'h41, 2);
    wait_idle("rr3_done");

    // Back-pressure in payload byte 2 and in CHECKSUM.
    tick();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h03); exp_q.push_back(8'h10);
    exp_q.push_back(8'h20); exp_q.push_back(8'h30); exp_q.push_back(8'h40);
    exp_q.push_back(8'h40);
    load(0, 3, 8'h10, 8'h10);
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) begin
        tick();
        bus.tx_wfull = ((k >= 4 && k <= 6) || k == 10);
      end
      @(negedge clk);
      if ((k >= 4 && k <= 6) || k == 10) begin
        check($sformatf("bp_winc_c%0d", k), int'(bus.tx_winc), 0);
        check($sformatf("bp_rd_c%0d", k), int'(bus.src_rd), 0);
        check($sformatf("bp_hold_c%0d", k), int'(bus.tx_wdata), (k == 10) ? 8'h40 : 8'h20);
      end
      if (k == 7) check("bp_resume", int'(bus.tx_wdata), 8'h20);
    end
    bus.tx_wfull = 1'b0;
    wait_idle("bp_done");

    // 256-byte payload.
    tick();
    base = rd_cnt[1];
    expect_frame(1, 255, 0, 1);
    check("len256_chk_model", int'(exp_q[exp_q.size() - 1]), 8'h00);
    load(1, 255, 0, 1);
    wait_idle("len256_done");
    check("len256_rd_pulses", rd_cnt[1] - base, 256);

    // Reset in the middle of a payload.
    tick();
    exp_q.push_back(8'hA0); exp_q.push_back(8'h03);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51);
    load(0, 3, 8'h50, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    flush_src(0);
    expect_frame(0, 0, 8'h61, 0);
    expect_frame(1, 0, 8'h71, 0);
    load(1, 0, 8'h71, 0);
    load(0, 0, 8'h61, 0);
    @(negedge clk);
    check("midrst_grant", int'(bus.grant), 0);
    check("midrst_winc", int'(bus.tx_winc), 0);
    check("midrst_busy", int'(bus.busy), 0);
    wait_idle("midrst_done");

    // FIFO already full when the request arrives.
    tick();
    bus.tx_wfull = 1'b1;
    expect_frame(0, 0, 8'h77, 0);
    load(0, 0, 8'h77, 0);
    @(negedge clk);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      check($sformatf("full_hdr_winc_c%0d", k), int'(bus.tx_winc), 0);
      check($sformatf("full_hdr_data_c%0d", k), int'(bus.tx_wdata), 8'hA0);
      check($sformatf("full_hdr_busy_c%0d", k), int'(bus.busy), 1);
    end
    tick();
    bus.tx_wfull = 1'b0;
    @(negedge clk);
    check("full_release_winc", int'(bus.tx_winc), 1);
    check("full_release_data", int'(bus.tx_wdata), 8'hA0);
    wait_idle("full_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
